// File: rtl/planta_pkg.sv
// rtl/planta_pkg.sv - shared states, ASCII constants and BCD helpers for the plant-controller serial link
package planta_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        ESPERA_LIBRE,
        INICIO,
        ESPERA_ACK,
        ESPERA_FIN
    } estado_t;

    localparam logic [7:0] ASCII_CERO    = 8'h30;
    localparam logic [7:0] ASCII_ERR     = 8'h3F;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam int         DIGITOS_TRAMA = 8;

    // Digits 0-9 become '0'..'9'; anything else is flagged on the wire as '?'
    function automatic logic [7:0] bcd_a_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n > 4'd9) begin
            r = ASCII_ERR;
        end else begin
            r = ASCII_CERO + {4'd0, n};
        end
        return r;
    endfunction

    // True when any of the eight nibbles of a record is not a valid BCD digit
    function automatic logic hay_error_bcd(input logic [31:0] r);
        logic e;
        e = 1'b0;
        for (int i = 0; i < DIGITOS_TRAMA; i++) begin
            if (r[4*i +: 4] > 4'd9) begin
                e = 1'b1;
            end
        end
        return e;
    endfunction

endpackage

// File: rtl/codificador.sv
// rtl/codificador.sv - frames a humidity/time/plant-type record as ASCII digits for the UART transmitter
module codificador
    import planta_pkg::*;
#(
    parameter bit FIN_LINEA = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enviar,
    input  logic [11:0] humedad,
    input  logic [15:0] hora,
    input  logic [3:0]  tipoPlanta,
    input  logic        ocupado_tx,
    output logic [7:0]  dato_tx,
    output logic        iniciar_tx,
    output logic        ocupado,
    output logic        terminado,
    output logic        error_bcd
);

    // Index of the final byte: the digits, plus CR LF when line endings are enabled
    localparam logic [3:0] ULTIMO = 4'(DIGITOS_TRAMA - 1 + (FIN_LINEA ? 2 : 0));

    estado_t     estado;
    logic [3:0]  indice;
    logic [31:0] sombra;
    logic [31:0] registro;
    logic [3:0]  nibble;
    logic [7:0]  byte_sel;

    assign registro = {humedad, hora, tipoPlanta};

    // Byte selector: digits come from the held record most-significant nibble first, then CR LF
    always_comb begin
        nibble   = 4'd0;
        byte_sel = 8'h00;
        case (indice)
            4'd0:    nibble = sombra[31:28];
            4'd1:    nibble = sombra[27:24];
            4'd2:    nibble = sombra[23:20];
            4'd3:    nibble = sombra[19:16];
            4'd4:    nibble = sombra[15:12];
            4'd5:    nibble = sombra[11:8];
            4'd6:    nibble = sombra[7:4];
            4'd7:    nibble = sombra[3:0];
            default: nibble = 4'd0;
        endcase
        if (indice == 4'd8) begin
            byte_sel = ASCII_CR;
        end else if (indice == 4'd9) begin
            byte_sel = ASCII_LF;
        end else begin
            byte_sel = bcd_a_ascii(nibble);
        end
    end

    // Frame sequencer: per byte wait for tx idle, load data, strobe, see busy rise, see busy fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= REPOSO;
            indice     <= 4'd0;
            sombra     <= 32'd0;
            dato_tx    <= 8'h00;
            iniciar_tx <= 1'b0;
            ocupado    <= 1'b0;
            terminado  <= 1'b0;
            error_bcd  <= 1'b0;
        end else begin
            iniciar_tx <= 1'b0;
            terminado  <= 1'b0;
            case (estado)
                REPOSO: begin
                    // A request coinciding with the end pulse belongs to the old frame and is dropped
                    if (enviar && !terminado) begin
                        sombra    <= registro;
                        indice    <= 4'd0;
                        error_bcd <= hay_error_bcd(registro);
                        ocupado   <= 1'b1;
                        estado    <= ESPERA_LIBRE;
                    end
                end
                ESPERA_LIBRE: begin
                    if (!ocupado_tx) begin
                        dato_tx <= byte_sel;
                        estado  <= INICIO;
                    end
                end
                INICIO: begin
                    iniciar_tx <= 1'b1;
                    estado     <= ESPERA_ACK;
                end
                ESPERA_ACK: begin
                    // No timeout: a slow tx is simply waited for, never re-strobed
                    if (ocupado_tx) begin
                        estado <= ESPERA_FIN;
                    end
                end
                ESPERA_FIN: begin
                    if (!ocupado_tx) begin
                        if (indice == ULTIMO) begin
                            terminado <= 1'b1;
                            ocupado   <= 1'b0;
                            estado    <= REPOSO;
                        end else begin
                            indice <= indice + 4'd1;
                            estado <= ESPERA_LIBRE;
                        end
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule
